// File: rtl/mem_arbiter_pkg.sv
// Shared types for the round-robin host memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_DATA  = 2'd1,
    WRITE_DATA = 2'd2
  } arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the client-side and host-side channels of the memory arbiter.
interface mem_arbiter_if #(
  parameter int NUM_CLIENTS   = 2,
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64
);

  logic [NUM_CLIENTS-1:0]               cl_req_valid;
  logic [NUM_CLIENTS-1:0]               cl_req_ready;
  logic [NUM_CLIENTS-1:0]               cl_req_opcode;
  logic [NUM_CLIENTS*MEM_LEN_BITS-1:0]  cl_req_len;
  logic [NUM_CLIENTS*MEM_ADDR_BITS-1:0] cl_req_addr;
  logic [NUM_CLIENTS-1:0]               cl_wr_valid;
  logic [NUM_CLIENTS*MEM_DATA_BITS-1:0] cl_wr_bits;
  logic [NUM_CLIENTS-1:0]               cl_rd_valid;
  logic [MEM_DATA_BITS-1:0]             cl_rd_bits;
  logic [NUM_CLIENTS-1:0]               cl_rd_ready;

  logic                     mem_req_valid;
  logic                     mem_req_opcode;
  logic [MEM_LEN_BITS-1:0]  mem_req_len;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_wr_valid;
  logic [MEM_DATA_BITS-1:0] mem_wr_bits;
  logic                     mem_rd_valid;
  logic [MEM_DATA_BITS-1:0] mem_rd_bits;
  logic                     mem_rd_ready;

  // A request or read beat moves in any cycle where valid and ready are both
  // high; write beats have no ready and move in every cycle wr_valid is high.
  modport master (
    input  cl_req_valid, cl_req_opcode, cl_req_len, cl_req_addr,
    input  cl_wr_valid, cl_wr_bits, cl_rd_ready,
    input  mem_rd_valid, mem_rd_bits,
    output cl_req_ready, cl_rd_valid, cl_rd_bits,
    output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    output mem_wr_valid, mem_wr_bits, mem_rd_ready
  );

  modport slave (
    output cl_req_valid, cl_req_opcode, cl_req_len, cl_req_addr,
    output cl_wr_valid, cl_wr_bits, cl_rd_ready,
    output mem_rd_valid, mem_rd_bits,
    input  cl_req_ready, cl_rd_valid, cl_rd_bits,
    input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    input  mem_wr_valid, mem_wr_bits, mem_rd_ready
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  always_comb begin
    int j;
    j         = 0;
    idx       = '0;
    any_valid = 1'b0;
    grant     = '0;
    // Walk from farthest to nearest so the nearest requester wins last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        idx       = IDX_W'(j);
        any_valid = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      grant[i] = any_valid && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one host memory port among NUM_CLIENTS requesters.
// Optional per-client grant counters are built when MEM_ARBITER_STATS_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS    = 2,
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64,
  parameter int HOST_DATA_BITS = 32,
  localparam int IDX_W         = $clog2(NUM_CLIENTS)
) (
  input  logic                                clock,
  input  logic                                reset,
  mem_arbiter_if.master                       bus,
  output logic [NUM_CLIENTS*HOST_DATA_BITS-1:0] stats_grant_cnt,
  output arb_state_t                          dbg_state,
  output logic [IDX_W-1:0]                    dbg_rr_ptr
);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [MEM_LEN_BITS-1:0] beats_q, beats_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic [NUM_CLIENTS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic                     win_opcode;
  logic [MEM_LEN_BITS-1:0]  win_len;
  logic [MEM_ADDR_BITS-1:0] win_addr;
  logic                     own_wr_valid;
  logic [MEM_DATA_BITS-1:0] own_wr_bits;
  logic                     own_rd_ready;

  logic [NUM_CLIENTS-1:0]   req_ready;
  logic                     req_valid;
  logic                     req_opcode;
  logic [MEM_LEN_BITS-1:0]  req_len;
  logic [MEM_ADDR_BITS-1:0] req_addr;
  logic                     wr_valid;
  logic [MEM_DATA_BITS-1:0] wr_bits;
  logic                     rd_ready;
  logic [NUM_CLIENTS-1:0]   rd_valid;
  logic [MEM_DATA_BITS-1:0] rd_bits;

  rr_pick #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick (
    .req       (bus.cl_req_valid),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    win_opcode   = 1'b0;
    win_len      = '0;
    win_addr     = '0;
    own_wr_valid = 1'b0;
    own_wr_bits  = '0;
    own_rd_ready = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        win_opcode = bus.cl_req_opcode[i];
        win_len    = bus.cl_req_len[i*MEM_LEN_BITS +: MEM_LEN_BITS];
        win_addr   = bus.cl_req_addr[i*MEM_ADDR_BITS +: MEM_ADDR_BITS];
      end
      if (owner_q == IDX_W'(i)) begin
        own_wr_valid = bus.cl_wr_valid[i];
        own_wr_bits  = bus.cl_wr_bits[i*MEM_DATA_BITS +: MEM_DATA_BITS];
        own_rd_ready = bus.cl_rd_ready[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beats_d    = beats_q;
    rr_ptr_d   = rr_ptr_q;
    req_ready  = '0;
    req_valid  = 1'b0;
    req_opcode = 1'b0;
    req_len    = '0;
    req_addr   = '0;
    wr_valid   = 1'b0;
    wr_bits    = '0;
    rd_ready   = 1'b0;
    rd_valid   = '0;
    rd_bits    = '0;
    // Outputs stay quiet during reset so no grant escapes into an abandoned cycle.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            req_valid  = 1'b1;
            req_ready  = pick_grant;
            req_opcode = win_opcode;
            req_len    = win_len;
            req_addr   = win_addr;
            owner_d    = pick_idx;
            beats_d    = win_len;
            rr_ptr_d   = (pick_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : pick_idx + IDX_W'(1);
            state_d    = (win_opcode == OP_READ) ? READ_DATA : WRITE_DATA;
          end
        end
        READ_DATA: begin
          rd_ready = own_rd_ready;
          rd_bits  = bus.mem_rd_bits;
          for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_valid[i] = bus.mem_rd_valid && (owner_q == IDX_W'(i));
          end
          if (bus.mem_rd_valid && own_rd_ready) begin
            if (beats_q == '0) state_d = IDLE;
            else               beats_d = beats_q - MEM_LEN_BITS'(1);
          end
        end
        WRITE_DATA: begin
          wr_valid = own_wr_valid;
          wr_bits  = own_wr_bits;
          if (own_wr_valid) begin
            if (beats_q == '0) state_d = IDLE;
            else               beats_d = beats_q - MEM_LEN_BITS'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      beats_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      beats_q  <= beats_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.cl_req_ready   = req_ready;
  assign bus.mem_req_valid  = req_valid;
  assign bus.mem_req_opcode = req_opcode;
  assign bus.mem_req_len    = req_len;
  assign bus.mem_req_addr   = req_addr;
  assign bus.mem_wr_valid   = wr_valid;
  assign bus.mem_wr_bits    = wr_bits;
  assign bus.mem_rd_ready   = rd_ready;
  assign bus.cl_rd_valid    = rd_valid;
  assign bus.cl_rd_bits     = rd_bits;

  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [HOST_DATA_BITS-1:0] cnt_q [NUM_CLIENTS];
  logic [HOST_DATA_BITS-1:0] cnt_d [NUM_CLIENTS];

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cnt_d[i] = cnt_q[i] + HOST_DATA_BITS'(req_ready[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    stats_grant_cnt = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      stats_grant_cnt[i*HOST_DATA_BITS +: HOST_DATA_BITS] = cnt_q[i];
    end
  end
`else
  assign stats_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with two clients.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int LW = 8;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int HW = 32;

  logic clock;
  logic reset;
  logic [N*HW-1:0] stats;
  arb_state_t dbg_state;
  logic dbg_rr;

  mem_arbiter_if #(.NUM_CLIENTS(N), .MEM_LEN_BITS(LW), .MEM_ADDR_BITS(AW),
                   .MEM_DATA_BITS(DW)) ifc ();

  mem_arbiter #(.NUM_CLIENTS(N), .MEM_LEN_BITS(LW), .MEM_ADDR_BITS(AW),
                .MEM_DATA_BITS(DW), .HOST_DATA_BITS(HW)) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (ifc),
    .stats_grant_cnt (stats),
    .dbg_state       (dbg_state),
    .dbg_rr_ptr      (dbg_rr)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt [N];

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  opc;
    logic [63:0] a0;
    logic [63:0] a1;
    logic [63:0] data;
    logic [1:0]  exp_rdy;
    logic        exp_op;
    logic [63:0] exp_addr;
    logic        exp_rr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_chk(input string name, input logic [63:0] act);
    logic [63:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h with no expected beat queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, e);
      end
    end
  endtask

  // driver tasks
  task automatic clear_in();
    ifc.cl_req_valid  = '0;
    ifc.cl_req_opcode = '0;
    ifc.cl_req_len    = '0;
    ifc.cl_req_addr   = '0;
    ifc.cl_wr_valid   = '0;
    ifc.cl_wr_bits    = '0;
    ifc.cl_rd_ready   = '0;
    ifc.mem_rd_valid  = 1'b0;
    ifc.mem_rd_bits   = '0;
  endtask

  task automatic note_grant(input int owner);
    exp_cnt[owner]++;
  endtask

  // One single-beat transaction: grant cycle, data beat, idle check.
  task automatic do_txn1(input vec_t v, input string tag);
    int owner;
    @(posedge clock); #1;
    ifc.cl_req_valid  = v.req;
    ifc.cl_req_opcode = v.opc;
    ifc.cl_req_len    = '0;
    ifc.cl_req_addr   = {v.a1, v.a0};
    @(negedge clock);
    chk({tag, "_req_ready"}, 64'(ifc.cl_req_ready), 64'(v.exp_rdy));
    chk({tag, "_req_valid"}, 64'(ifc.mem_req_valid), 64'(v.exp_rdy != 2'b00));
    if (v.exp_rdy != 2'b00) begin
      chk({tag, "_req_op"}, 64'(ifc.mem_req_opcode), 64'(v.exp_op));
      chk({tag, "_req_addr"}, ifc.mem_req_addr, v.exp_addr);
      chk({tag, "_req_len"}, 64'(ifc.mem_req_len), 64'd0);
    end
    @(posedge clock); #1;
    clear_in();
    if (v.exp_rdy != 2'b00) begin
      owner = v.exp_rdy[1] ? 1 : 0;
      note_grant(owner);
      if (v.exp_op == OP_READ) begin
        ifc.mem_rd_valid = 1'b1;
        ifc.mem_rd_bits  = v.data;
        ifc.cl_rd_ready  = 2'b11;
        exp_q.push_back(v.data);
        @(negedge clock);
        chk({tag, "_st_rd"}, 64'(dbg_state), 64'(READ_DATA));
        chk({tag, "_rd_valid"}, 64'(ifc.cl_rd_valid), 64'(v.exp_rdy));
        chk({tag, "_rd_ready"}, 64'(ifc.mem_rd_ready), 64'd1);
        chk({tag, "_busy_ready"}, 64'(ifc.cl_req_ready), 64'd0);
        sb_chk({tag, "_rd_bits"}, ifc.cl_rd_bits);
      end else begin
        ifc.cl_wr_valid = 2'b11;
        ifc.cl_wr_bits  = owner == 1 ? {v.data, ~v.data} : {~v.data, v.data};
        exp_q.push_back(v.data);
        @(negedge clock);
        chk({tag, "_st_wr"}, 64'(dbg_state), 64'(WRITE_DATA));
        chk({tag, "_wr_valid"}, 64'(ifc.mem_wr_valid), 64'd1);
        sb_chk({tag, "_wr_bits"}, ifc.mem_wr_bits);
      end
      @(posedge clock); #1;
      clear_in();
    end
    @(negedge clock);
    chk({tag, "_st_idle"}, 64'(dbg_state), 64'(IDLE));
    chk({tag, "_rr"}, 64'(dbg_rr), 64'(v.exp_rr));
  endtask

  initial begin
    logic [5:0] rdy_pat;
    vec_t v;
    logic [63:0] d;
    int sent, seen, cyc, bcnt;
    logic wv;

    vecs[0] = '{2'b11, 2'b11, 64'h1000, 64'h1100, 64'h11, 2'b01, 1'b1, 64'h1000, 1'b1};
    vecs[1] = '{2'b11, 2'b11, 64'h1200, 64'h1300, 64'h22, 2'b10, 1'b1, 64'h1300, 1'b0};
    vecs[2] = '{2'b11, 2'b11, 64'h1400, 64'h1500, 64'h33, 2'b01, 1'b1, 64'h1400, 1'b1};
    vecs[3] = '{2'b01, 2'b00, 64'h0100, 64'h1700, 64'hAB, 2'b01, 1'b0, 64'h0100, 1'b1};
    vecs[4] = '{2'b00, 2'b00, 64'h1800, 64'h1900, 64'h00, 2'b00, 1'b0, 64'h0000, 1'b1};
    vecs[5] = '{2'b10, 2'b00, 64'h1a00, 64'h1b00, 64'h55, 2'b10, 1'b0, 64'h1b00, 1'b0};
    vecs[6] = '{2'b10, 2'b10, 64'h1c00, 64'h1d00, 64'h66, 2'b10, 1'b1, 64'h1d00, 1'b0};
    vecs[7] = '{2'b11, 2'b10, 64'h1e00, 64'h1f00, 64'h77, 2'b01, 1'b0, 64'h1e00, 1'b1};
    vecs[8] = '{2'b11, 2'b01, 64'h2000, 64'h2100, 64'h88, 2'b10, 1'b0, 64'h2100, 1'b0};
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;

    clear_in();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_rr", 64'(dbg_rr), 64'd0);
    chk("rst_req_valid", 64'(ifc.mem_req_valid), 64'd0);
    chk("rst_cl_ready", 64'(ifc.cl_req_ready), 64'd0);
    chk("rst_stats", stats, 64'd0);

    // table-driven single-beat transactions
    for (int i = 0; i < 9; i++) do_txn1(vecs[i], $sformatf("v%0d", i));

    // client 1 read, len=3, ready toggling; client 0 waits
    rdy_pat = 6'b101101;  // bit k = ready in beat cycle k
    @(posedge clock); #1;
    ifc.cl_req_valid = 2'b10;
    ifc.cl_req_len   = {8'd3, 8'd0};
    ifc.cl_req_addr  = {64'h3000, 64'h0};
    @(negedge clock);
    chk("burst_grant", 64'(ifc.cl_req_ready), 64'b10);
    chk("burst_len", 64'(ifc.mem_req_len), 64'd3);
    note_grant(1);
    bcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      ifc.cl_req_valid  = 2'b01;
      ifc.cl_req_opcode = 2'b00;
      ifc.cl_req_len    = '0;
      ifc.cl_req_addr   = {64'h0, 64'h4000};
      ifc.cl_rd_ready   = {rdy_pat[k], ~rdy_pat[k]};
      ifc.mem_rd_valid  = 1'b1;
      ifc.mem_rd_bits   = 64'h5000 + 64'(k);
      if (rdy_pat[k]) exp_q.push_back(64'h5000 + 64'(k));
      @(negedge clock);
      chk($sformatf("burst_st%0d", k), 64'(dbg_state), 64'(READ_DATA));
      chk($sformatf("burst_mrdy%0d", k), 64'(ifc.mem_rd_ready), 64'(rdy_pat[k]));
      chk($sformatf("burst_rdv%0d", k), 64'(ifc.cl_rd_valid), 64'b10);
      chk($sformatf("burst_wait%0d", k), 64'(ifc.cl_req_ready), 64'd0);
      if (rdy_pat[k]) begin
        sb_chk($sformatf("burst_bits%0d", k), ifc.cl_rd_bits);
        bcnt++;
      end
    end
    @(posedge clock); #1;
    ifc.mem_rd_bits = 64'hdead;
    @(negedge clock);
    chk("burst_done_st", 64'(dbg_state), 64'(IDLE));
    chk("burst_done_rdv", 64'(ifc.cl_rd_valid), 64'd0);
    chk("burst_next_grant", 64'(ifc.cl_req_ready), 64'b01);
    chk("burst_next_addr", ifc.mem_req_addr, 64'h4000);
    chk("burst_beats", 64'(bcnt), 64'd4);
    note_grant(0);
    @(posedge clock); #1;
    clear_in();
    ifc.mem_rd_valid = 1'b1;
    ifc.mem_rd_bits  = 64'h6000;
    ifc.cl_rd_ready  = 2'b01;
    exp_q.push_back(64'h6000);
    @(negedge clock);
    chk("c0_rd_valid", 64'(ifc.cl_rd_valid), 64'b01);
    sb_chk("c0_rd_bits", ifc.cl_rd_bits);
    @(posedge clock); #1;
    clear_in();
    @(negedge clock);
    chk("c0_done_st", 64'(dbg_state), 64'(IDLE));
    chk("c0_done_rr", 64'(dbg_rr), 64'd1);

    // client 0 write, len=255: 256 beats with random gaps
    @(posedge clock); #1;
    ifc.cl_req_valid  = 2'b01;
    ifc.cl_req_opcode = 2'b01;
    ifc.cl_req_len    = {8'd0, 8'd255};
    ifc.cl_req_addr   = {64'h0, 64'h8000};
    @(negedge clock);
    chk("long_grant", 64'(ifc.cl_req_ready), 64'b01);
    chk("long_len", 64'(ifc.mem_req_len), 64'd255);
    chk("long_op", 64'(ifc.mem_req_opcode), 64'd1);
    note_grant(0);
    @(posedge clock); #1;
    clear_in();
    sent = 0; seen = 0; cyc = 0;
    while (sent < 256 && cyc < 2000) begin
      wv = ($urandom_range(0, 3) != 0);
      d  = {$urandom, $urandom};
      ifc.cl_wr_valid = {1'($urandom_range(0, 1)), wv};
      ifc.cl_wr_bits  = {{$urandom, $urandom}, d};
      if (wv) exp_q.push_back(d);
      @(negedge clock);
      chk("long_st", 64'(dbg_state), 64'(WRITE_DATA));
      chk("long_wr_valid", 64'(ifc.mem_wr_valid), 64'(wv));
      if (ifc.mem_wr_valid) begin
        sb_chk("long_wr_bits", ifc.mem_wr_bits);
        seen++;
      end
      if (wv) sent++;
      cyc++;
      @(posedge clock); #1;
    end
    chk("long_timeout", 64'(cyc < 2000), 64'd1);
    ifc.cl_wr_valid = 2'b01;
    ifc.cl_wr_bits  = {64'h0, 64'hbeef};
    @(negedge clock);
    chk("long_beats", 64'(seen), 64'd256);
    chk("long_done_st", 64'(dbg_state), 64'(IDLE));
    chk("long_stray_wr", 64'(ifc.mem_wr_valid), 64'd0);
    clear_in();

    // reset during beat 2 of a 4-beat read by client 1
    @(posedge clock); #1;
    ifc.cl_req_valid = 2'b10;
    ifc.cl_req_len   = {8'd3, 8'd0};
    ifc.cl_req_addr  = {64'h9000, 64'h0};
    @(negedge clock);
    chk("rstb_grant", 64'(ifc.cl_req_ready), 64'b10);
    @(posedge clock); #1;
    clear_in();
    ifc.mem_rd_valid = 1'b1;
    ifc.mem_rd_bits  = 64'h7001;
    ifc.cl_rd_ready  = 2'b11;
    exp_q.push_back(64'h7001);
    @(negedge clock);
    chk("rstb_rdv", 64'(ifc.cl_rd_valid), 64'b10);
    sb_chk("rstb_bits", ifc.cl_rd_bits);
    @(posedge clock); #1;
    reset = 1'b1;
    ifc.mem_rd_bits = 64'h7002;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    ifc.mem_rd_valid = 1'b1;
    ifc.cl_rd_ready  = 2'b11;
    ifc.cl_wr_valid  = 2'b11;
    @(negedge clock);
    chk("rstb_state", 64'(dbg_state), 64'(IDLE));
    chk("rstb_rr", 64'(dbg_rr), 64'd0);
    chk("rstb_rdv_zero", 64'(ifc.cl_rd_valid), 64'd0);
    chk("rstb_rdbits_zero", ifc.cl_rd_bits, 64'd0);
    chk("rstb_mrdy_zero", 64'(ifc.mem_rd_ready), 64'd0);
    chk("rstb_wrv_zero", 64'(ifc.mem_wr_valid), 64'd0);
    chk("rstb_reqv_zero", 64'(ifc.mem_req_valid), 64'd0);
    chk("rstb_stats", stats, 64'd0);
    clear_in();

    // post-reset: 3 grants to client 0, 2 to client 1
    v = '{2'b11, 2'b11, 64'hA000, 64'hA100, 64'hC1, 2'b01, 1'b1, 64'hA000, 1'b1};
    do_txn1(v, "pr0");
    v = '{2'b11, 2'b11, 64'hA200, 64'hA300, 64'hC2, 2'b10, 1'b1, 64'hA300, 1'b0};
    do_txn1(v, "pr1");
    v = '{2'b11, 2'b00, 64'hA400, 64'hA500, 64'hC3, 2'b01, 1'b0, 64'hA400, 1'b1};
    do_txn1(v, "pr2");
    v = '{2'b11, 2'b00, 64'hA600, 64'hA700, 64'hC4, 2'b10, 1'b0, 64'hA700, 1'b0};
    do_txn1(v, "pr3");
    v = '{2'b01, 2'b01, 64'hA800, 64'hA900, 64'hC5, 2'b01, 1'b1, 64'hA800, 1'b1};
    do_txn1(v, "pr4");

    for (int i = 0; i < N; i++) begin
`ifdef MEM_ARBITER_STATS_EN
      chk($sformatf("stats%0d", i), 64'(stats[i*HW +: HW]), 64'(exp_cnt[i]));
`else
      chk($sformatf("stats%0d", i), 64'(stats[i*HW +: HW]), 64'd0);
`endif
    end
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
